// File: rtl/agc_stats_pkg.sv
// Shared state type, LFSR constants and combinational helpers for the AGC statistics engine.
// Pure functions only: no latency, no backpressure.
package agc_stats_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } agc_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed on the right-shifting register: bits 0,2,3,5 feed bit 15.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
    localparam int          MIN_LOG2 = 4;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {^(l & LFSR_TAP_MASK), l[15:1]};
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [4:0] clamp_len(input logic [4:0] l, input logic [4:0] max_l);
        if (l < 5'(MIN_LOG2)) begin
            return 5'(MIN_LOG2);
        end else if (l > max_l) begin
            return max_l;
        end
        return l;
    endfunction

endpackage

// File: rtl/agc_stats_engine_if.sv
// Port bundle for agc_stats_engine: per-channel sample inputs, measurement control and capture readout.
// Optional AGC_PEAK_HOLD_EN widens rd_data_o by ABITS for the per-channel peak.
interface agc_stats_engine_if #(
    parameter int NCHAN   = 8,
    parameter int NSAMP   = 8,
    parameter int ABITS   = 4,
    parameter int SQ_BITS = 24,
    parameter int PR_BITS = 21
);
    localparam int CH_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;
`ifdef AGC_PEAK_HOLD_EN
    localparam int PK_W = ABITS;
`else
    localparam int PK_W = 0;
`endif
    localparam int RD_W = PK_W + SQ_BITS + 2 * PR_BITS;

    logic [NCHAN*NSAMP*ABITS-1:0] abs_i;
    logic [NCHAN*NSAMP-1:0]       gt_i;
    logic [NCHAN*NSAMP-1:0]       lt_i;
    logic                         start_i;
    logic                         cont_i;
    logic [4:0]                   len_log2_i;
    logic                         busy_o;
    logic                         done_o;
    logic                         ack_i;
    logic                         ovf_o;
    logic                         rd_stb_i;
    logic [CH_BITS-1:0]           rd_ch_i;
    logic                         rd_valid_o;
    logic [RD_W-1:0]              rd_data_o;

    modport master (
        output abs_i, gt_i, lt_i, start_i, cont_i, len_log2_i, ack_i, rd_stb_i, rd_ch_i,
        input  busy_o, done_o, ovf_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  abs_i, gt_i, lt_i, start_i, cont_i, len_log2_i, ack_i, rd_stb_i, rd_ch_i,
        output busy_o, done_o, ovf_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/agc_stats_chan.sv
// One channel's saturating square/gt/lt accumulators (plus peak under AGC_PEAK_HOLD_EN).
// Updates on the clock edge after the sample; clr_i overrides en_i; no backpressure.
module agc_stats_chan
    import agc_stats_pkg::*;
#(
    parameter int NSAMP     = 8,
    parameter int ABITS     = 4,
    parameter int SQ_BITS   = 24,
    parameter int PR_BITS   = 21,
    parameter int SQ_OFFSET = 16384,
    localparam int SEL_W    = $clog2(NSAMP)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NSAMP*ABITS-1:0]   abs_i,
    input  logic [NSAMP-1:0]         gt_i,
    input  logic [NSAMP-1:0]         lt_i,
`ifdef AGC_PEAK_HOLD_EN
    output logic [ABITS-1:0]         pk_o,
`endif
    output logic [SQ_BITS-1:0]       sq_o,
    output logic [PR_BITS-1:0]       gt_o,
    output logic [PR_BITS-1:0]       lt_o
);

    logic [SQ_BITS-1:0] sq_q, sq_d;
    logic [PR_BITS-1:0] gt_q, gt_d, lt_q, lt_d;
    logic [ABITS-1:0]   abs_sel;
    logic [2*ABITS-1:0] abs_sq;
    logic [SQ_BITS:0]   sq_sum;
    logic [PR_BITS:0]   gt_sum, lt_sum;

    always_comb begin
        abs_sel = abs_i[sel_i*ABITS +: ABITS];
        abs_sq  = abs_sel * abs_sel;
        sq_sum  = {1'b0, sq_q} + (SQ_BITS+1)'(abs_sq);
        gt_sum  = {1'b0, gt_q} + (PR_BITS+1)'(popcount16(16'(gt_i)));
        lt_sum  = {1'b0, lt_q} + (PR_BITS+1)'(popcount16(16'(lt_i)));

        sq_d = sq_q;
        gt_d = gt_q;
        lt_d = lt_q;
        if (clr_i) begin
            sq_d = SQ_BITS'(SQ_OFFSET);
            gt_d = '0;
            lt_d = '0;
        end else if (en_i) begin
            // The carry bit of each sum flags overflow: pin at all-ones instead of wrapping.
            sq_d = sq_sum[SQ_BITS] ? '1 : sq_sum[SQ_BITS-1:0];
            gt_d = gt_sum[PR_BITS] ? '1 : gt_sum[PR_BITS-1:0];
            lt_d = lt_sum[PR_BITS] ? '1 : lt_sum[PR_BITS-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sq_q <= SQ_BITS'(SQ_OFFSET);
            gt_q <= '0;
            lt_q <= '0;
        end else begin
            sq_q <= sq_d;
            gt_q <= gt_d;
            lt_q <= lt_d;
        end
    end

    assign sq_o = sq_q;
    assign gt_o = gt_q;
    assign lt_o = lt_q;

`ifdef AGC_PEAK_HOLD_EN
    logic [ABITS-1:0] pk_q, pk_d, pk_max;

    always_comb begin
        pk_max = pk_q;
        for (int s = 0; s < NSAMP; s++) begin
            if (abs_i[s*ABITS +: ABITS] > pk_max) begin
                pk_max = abs_i[s*ABITS +: ABITS];
            end
        end
        pk_d = pk_q;
        if (clr_i) begin
            pk_d = '0;
        end else if (en_i) begin
            pk_d = pk_max;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pk_q <= '0;
        end else begin
            pk_q <= pk_d;
        end
    end

    assign pk_o = pk_q;
`endif

endmodule

// File: rtl/agc_stats_engine.sv
// Multi-channel AGC measurement engine: timer FSM, shared LFSR, per-channel accumulators, capture bank, readout.
// Read data one cycle after rd_stb_i; done_o one cycle after CAPTURE; no backpressure. Option: AGC_PEAK_HOLD_EN.
module agc_stats_engine
    import agc_stats_pkg::*;
#(
    parameter int NCHAN     = 8,
    parameter int NSAMP     = 8,
    parameter int ABITS     = 4,
    parameter int SQ_BITS   = 24,
    parameter int PR_BITS   = 21,
    parameter int SQ_OFFSET = 16384,
    parameter int MAX_LOG2  = 17
) (
    input logic               clk_i,
    input logic               rst_i,
    agc_stats_engine_if.slave bus
);

    localparam int SEL_W   = $clog2(NSAMP);
    localparam int CH_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;
`ifdef AGC_PEAK_HOLD_EN
    localparam int PK_W = ABITS;
`else
    localparam int PK_W = 0;
`endif
    localparam int LANE_W = PK_W + SQ_BITS + 2 * PR_BITS;

    agc_state_t          state_q, state_d;
    logic [MAX_LOG2-1:0] cnt_q, cnt_d, cnt_load;
    logic [MAX_LOG2:0]   span;
    logic [4:0]          len_c;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                acc_clr, acc_en, cap;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                rd_vld_q, rd_vld_d;
    logic [LANE_W-1:0]   rd_dat_q, rd_dat_d;
    logic [NCHAN-1:0][LANE_W-1:0] acc_w, bank_q, bank_d;

    for (genvar g = 0; g < NCHAN; g++) begin : g_chan
        logic [SQ_BITS-1:0] sq;
        logic [PR_BITS-1:0] gt;
        logic [PR_BITS-1:0] lt;
`ifdef AGC_PEAK_HOLD_EN
        logic [ABITS-1:0]   pk;
`endif

        agc_stats_chan #(
            .NSAMP    (NSAMP),
            .ABITS    (ABITS),
            .SQ_BITS  (SQ_BITS),
            .PR_BITS  (PR_BITS),
            .SQ_OFFSET(SQ_OFFSET)
        ) u_chan (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (acc_clr),
            .en_i  (acc_en),
            .sel_i (lfsr_q[SEL_W-1:0]),
            .abs_i (bus.abs_i[g*NSAMP*ABITS +: NSAMP*ABITS]),
            .gt_i  (bus.gt_i[g*NSAMP +: NSAMP]),
            .lt_i  (bus.lt_i[g*NSAMP +: NSAMP]),
`ifdef AGC_PEAK_HOLD_EN
            .pk_o  (pk),
`endif
            .sq_o  (sq),
            .gt_o  (gt),
            .lt_o  (lt)
        );

`ifdef AGC_PEAK_HOLD_EN
        assign acc_w[g] = {pk, sq, gt, lt};
`else
        assign acc_w[g] = {sq, gt, lt};
`endif
    end

    // Counter runs 2**len-1 down to 0, so RUN lasts exactly 2**len clocks.
    always_comb begin
        len_c    = clamp_len(bus.len_log2_i, 5'(MAX_LOG2));
        span     = (MAX_LOG2+1)'(1) << len_c;
        cnt_load = MAX_LOG2'(span - (MAX_LOG2+1)'(1));

        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    cnt_d   = cnt_load;
                    acc_clr = 1'b1;
                end
            end
            RUN: begin
                acc_en = 1'b1;
                lfsr_d = lfsr_next(lfsr_q);
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                cap = 1'b1;
                if (bus.cont_i) begin
                    state_d = RUN;
                    cnt_d   = cnt_load;
                    acc_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = cap;
        bank_d = cap ? acc_w : bank_q;
        // An ack arriving with a capture loses: the fresh bank is still unread.
        pend_d = cap ? 1'b1 : (bus.ack_i ? 1'b0 : pend_q);
        ovf_d  = ovf_q | (cap & pend_q);

        rd_vld_d = bus.rd_stb_i;
        rd_dat_d = rd_dat_q;
        if (bus.rd_stb_i) begin
            rd_dat_d = ({1'b0, bus.rd_ch_i} < (CH_BITS+1)'(NCHAN)) ? bank_q[bus.rd_ch_i] : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bank_q   <= '0;
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            bank_q   <= bank_d;
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.ovf_o      = ovf_q;
    assign bus.rd_valid_o = rd_vld_q;
    assign bus.rd_data_o  = rd_dat_q;

endmodule

// File: tb/tb_agc_stats_engine.sv
// Bench for agc_stats_engine: two instances (wide and narrow accumulators) against one behavioural model.
module tb_agc_stats_engine;

    localparam int NCH = 3;
    localparam int NS  = 8;
    localparam int AB  = 4;
    localparam int NB  = NCH * NS;
    localparam int SQA = 24;
    localparam int PRA = 21;
    localparam int SQB = 15;
    localparam int PRB = 6;
`ifdef AGC_PEAK_HOLD_EN
    localparam bit HAS_PK = 1'b1;
`else
    localparam bit HAS_PK = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    agc_stats_engine_if #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQA), .PR_BITS(PRA)) ifa ();
    agc_stats_engine_if #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQB), .PR_BITS(PRB)) ifb ();

    agc_stats_engine #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQA), .PR_BITS(PRA),
                       .SQ_OFFSET(16384), .MAX_LOG2(17))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));

    agc_stats_engine #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQB), .PR_BITS(PRB),
                       .SQ_OFFSET(16384), .MAX_LOG2(17))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));

    assign ifb.abs_i      = ifa.abs_i;
    assign ifb.gt_i       = ifa.gt_i;
    assign ifb.lt_i       = ifa.lt_i;
    assign ifb.start_i    = ifa.start_i;
    assign ifb.cont_i     = ifa.cont_i;
    assign ifb.len_log2_i = ifa.len_log2_i;
    assign ifb.ack_i      = ifa.ack_i;
    assign ifb.rd_stb_i   = ifa.rd_stb_i;
    assign ifb.rd_ch_i    = ifa.rd_ch_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    function automatic int clamp_len(input int l);
        return (l < 4) ? 4 : ((l > 17) ? 17 : l);
    endfunction

    // ---------------- behavioural model (unbounded sums, saturated only when compared) ----------------
    localparam int S_IDLE = 0, S_RUN = 1, S_CAP = 2;
    int          m_state, m_left, prev_state;
    int unsigned m_lfsr;
    bit          m_pend, m_ok;
    longint      m_sq[NCH], m_gt[NCH], m_lt[NCH], m_pk[NCH];
    longint      bk_sq[NCH], bk_gt[NCH], bk_lt[NCH], bk_pk[NCH];
    bit          e_busy, e_done, e_ovf, e_vld;
    longint      e_sq, e_gt, e_lt, e_pk;

    function automatic longint sample_abs(input int c, input int s);
        return longint'(ifa.abs_i[(c*NS+s)*AB +: AB]);
    endfunction

    task automatic clear_acc();
        for (int c = 0; c < NCH; c++) begin
            m_sq[c] = 16384; m_gt[c] = 0; m_lt[c] = 0; m_pk[c] = 0;
        end
    endtask

    always @(posedge clk) begin
        m_ok = 1'b1;
        if (rst) begin
            m_state = S_IDLE; m_left = 0; m_lfsr = 32'hACE1; m_pend = 0;
            e_busy = 0; e_done = 0; e_ovf = 0; e_vld = 0;
            e_sq = 0; e_gt = 0; e_lt = 0; e_pk = 0;
            clear_acc();
            for (int c = 0; c < NCH; c++) begin
                bk_sq[c] = 0; bk_gt[c] = 0; bk_lt[c] = 0; bk_pk[c] = 0;
            end
        end else begin
            e_vld = ifa.rd_stb_i;
            if (ifa.rd_stb_i) begin
                if (int'(ifa.rd_ch_i) < NCH) begin
                    e_sq = bk_sq[ifa.rd_ch_i]; e_gt = bk_gt[ifa.rd_ch_i];
                    e_lt = bk_lt[ifa.rd_ch_i]; e_pk = bk_pk[ifa.rd_ch_i];
                end else begin
                    e_sq = 0; e_gt = 0; e_lt = 0; e_pk = 0;
                end
            end
            e_done = 0;
            prev_state = m_state;
            case (m_state)
                S_IDLE: if (ifa.start_i) begin
                    m_state = S_RUN; m_left = 1 << clamp_len(int'(ifa.len_log2_i)); clear_acc();
                end
                S_RUN: begin
                    for (int c = 0; c < NCH; c++) begin
                        m_sq[c] += sample_abs(c, int'(m_lfsr % NS)) ** 2;
                        m_gt[c] += $countones(ifa.gt_i[c*NS +: NS]);
                        m_lt[c] += $countones(ifa.lt_i[c*NS +: NS]);
                        for (int s = 0; s < NS; s++)
                            if (sample_abs(c, s) > m_pk[c]) m_pk[c] = sample_abs(c, s);
                    end
                    m_lfsr = (m_lfsr >> 1) |
                             (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
                    m_left--;
                    if (m_left == 0) m_state = S_CAP;
                end
                default: begin
                    for (int c = 0; c < NCH; c++) begin
                        bk_sq[c] = m_sq[c]; bk_gt[c] = m_gt[c]; bk_lt[c] = m_lt[c]; bk_pk[c] = m_pk[c];
                    end
                    e_done = 1;
                    if (m_pend) e_ovf = 1;
                    m_pend = 1;
                    if (ifa.cont_i) begin
                        m_state = S_RUN; m_left = 1 << clamp_len(int'(ifa.len_log2_i)); clear_acc();
                    end else begin
                        m_state = S_IDLE;
                    end
                end
            endcase
            if (prev_state != S_CAP && ifa.ack_i) m_pend = 0;
            e_busy = (m_state != S_IDLE);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy_a", ifa.busy_o, e_busy);
            chk("done_a", ifa.done_o, e_done);
            chk("ovf_a", ifa.ovf_o, e_ovf);
            chk("rdvld_a", ifa.rd_valid_o, e_vld);
            chk("rdsq_a", ifa.rd_data_o[2*PRA +: SQA], sat(e_sq, SQA));
            chk("rdgt_a", ifa.rd_data_o[PRA +: PRA], sat(e_gt, PRA));
            chk("rdlt_a", ifa.rd_data_o[0 +: PRA], sat(e_lt, PRA));
            chk("busy_b", ifb.busy_o, e_busy);
            chk("done_b", ifb.done_o, e_done);
            chk("ovf_b", ifb.ovf_o, e_ovf);
            chk("rdsq_b", ifb.rd_data_o[2*PRB +: SQB], sat(e_sq, SQB));
            chk("rdgt_b", ifb.rd_data_o[PRB +: PRB], sat(e_gt, PRB));
            chk("rdlt_b", ifb.rd_data_o[0 +: PRB], sat(e_lt, PRB));
            if (HAS_PK) begin
                chk("rdpk_a", longint'(ifa.rd_data_o >> (SQA + 2*PRA)), e_pk);
                chk("rdpk_b", longint'(ifb.rd_data_o >> (SQB + 2*PRB)), e_pk);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input int c);
        ifa.rd_stb_i = 1'b1;
        ifa.rd_ch_i  = 2'(c);
        tick();
        ifa.rd_stb_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (ifa.done_o !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        chk("done_seen", ifa.done_o, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ifa.busy_o && n < 300) begin
            tick();
            n++;
        end
        chk("idle_reached", ifa.busy_o, 0);
    endtask

    task automatic set_ch(input int c, input logic [3:0] a, input logic [7:0] g, input logic [7:0] l);
        for (int s = 0; s < NS; s++) ifa.abs_i[(c*NS+s)*AB +: AB] = a;
        ifa.gt_i[c*NS +: NS] = g;
        ifa.lt_i[c*NS +: NS] = l;
    endtask

    task automatic pulse_start();
        ifa.start_i = 1'b1;
        tick();
        ifa.start_i = 1'b0;
    endtask

    initial begin
        int lat;
        n_cmp = 0; n_err = 0; m_ok = 1'b0;
        rst = 1'b1;
        ifa.abs_i = '0; ifa.gt_i = '0; ifa.lt_i = '0;
        ifa.start_i = 0; ifa.cont_i = 0; ifa.len_log2_i = 5'd4;
        ifa.ack_i = 0; ifa.rd_stb_i = 0; ifa.rd_ch_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", ifa.busy_o, 0);
        chk("reset_ovf", ifa.ovf_o, 0);
        rd(0);
        chk("reset_bank_sq", ifa.rd_data_o[2*PRA +: SQA], 0);

        // Basic period: ch0 abs=3 gt all, ch1 abs=0 lt[3:0], ch2 mixed.
        set_ch(0, 4'd3, 8'hFF, 8'h00);
        set_ch(1, 4'd0, 8'h00, 8'h0F);
        set_ch(2, 4'd5, 8'hAA, 8'h01);
        pulse_start();
        wait_done(lat);
        chk("done_latency", lat, 18);
        rd(0);
        chk("lit_ch0_vld", ifa.rd_valid_o, 1);
        chk("lit_ch0_sq", ifa.rd_data_o[2*PRA +: SQA], 16528);
        chk("lit_ch0_gt", ifa.rd_data_o[PRA +: PRA], 128);
        chk("lit_ch0_lt", ifa.rd_data_o[0 +: PRA], 0);
        chk("lit_b_gt_sat", ifb.rd_data_o[PRB +: PRB], 63);
        rd(1);
        chk("lit_ch1_sq", ifa.rd_data_o[2*PRA +: SQA], 16384);
        chk("lit_ch1_gt", ifa.rd_data_o[PRA +: PRA], 0);
        chk("lit_ch1_lt", ifa.rd_data_o[0 +: PRA], 64);
        chk("lit_b_lt_sat", ifb.rd_data_o[0 +: PRB], 63);
        rd(3);
        chk("lit_oob_vld", ifa.rd_valid_o, 1);
        chk("lit_oob_sq", ifa.rd_data_o[2*PRA +: SQA], 0);
        chk("lit_oob_gt", ifa.rd_data_o[PRA +: PRA], 0);
        tick();
        chk("lit_hold_vld", ifa.rd_valid_o, 0);
        ifa.ack_i = 1'b1; tick(); ifa.ack_i = 1'b0;

        // Continuous mode without ack: second capture overflows.
        ifa.cont_i = 1'b1;
        pulse_start();
        wait_done(lat);
        tick();
        wait_done(lat);
        chk("lit_ovf_set", ifa.ovf_o, 1);
        ifa.cont_i = 1'b0;
        wait_idle();
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("lit_ovf_clr_rst", ifa.ovf_o, 0);

        // Continuous mode with acks between captures: no overflow.
        ifa.cont_i = 1'b1;
        pulse_start();
        wait_done(lat);
        ifa.ack_i = 1'b1; tick(); ifa.ack_i = 1'b0;
        wait_done(lat);
        ifa.ack_i = 1'b1; tick(); ifa.ack_i = 1'b0;
        wait_done(lat);
        chk("lit_ovf_acked", ifa.ovf_o, 0);
        ifa.cont_i = 1'b0;
        ifa.ack_i = 1'b1; tick(); ifa.ack_i = 1'b0;
        wait_idle();

        // Reset mid-period.
        ifa.len_log2_i = 5'd5;
        pulse_start();
        repeat (5) tick();
        chk("lit_busy_run", ifa.busy_o, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("lit_busy_rst", ifa.busy_o, 0);
        rd(0);
        chk("lit_bank_rst", ifa.rd_data_o[PRA +: PRA], 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < NB; k++) ifa.abs_i[k*AB +: AB] = 4'($urandom);
            ifa.gt_i       = NB'($urandom);
            ifa.lt_i       = NB'($urandom);
            ifa.start_i    = ($urandom_range(0, 7) == 0);
            ifa.cont_i     = ($urandom_range(0, 3) == 0);
            ifa.len_log2_i = 5'($urandom_range(0, 6));
            ifa.ack_i      = ($urandom_range(0, 5) == 0);
            ifa.rd_stb_i   = ($urandom_range(0, 2) == 0);
            ifa.rd_ch_i    = 2'($urandom_range(0, 3));
            rst            = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
